data_mem: RTL and testbench

Data memory stage of the single-cycle MIPS datapath, directly downstream of the ALU. It takes the ALU result as a byte address and performs word, halfword or byte loads and stores on a 4 KiB word-organised array. Stores commit on the clock edge. Load data is produced combinationally so the write-back mux sees it within the same cycle. Misaligned and out-of-range accesses are flagged and never corrupt memory.

---
 rtl/dm_pkg.sv | 14 +
 rtl/dm_ext.sv | 28 ++
 rtl/data_mem.sv | 81 ++++++++
 tb/tb_data_mem.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// Shared memory-access definitions for the data memory stage and the controller
// that drives MemOp.
package dm_pkg;

  localparam logic [2:0] DM_W  = 3'b000;
  localparam logic [2:0] DM_H  = 3'b001;
  localparam logic [2:0] DM_HU = 3'b010;
  localparam logic [2:0] DM_B  = 3'b011;
  localparam logic [2:0] DM_BU = 3'b100;

  // One bit per byte lane; bit 0 is lane 0 (bits 7:0), little-endian.
  typedef logic [3:0] dm_be_t;

endpackage

// File: rtl/dm_ext.sv
// Combinational load extractor: selects the addressed half/byte from a word
// and sign- or zero-extends it according to the access type.
module dm_ext
  import dm_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [2:0]  op,
  output logic [31:0] rd
);

  logic [15:0] half_v;
  logic [7:0]  lane_byte;

  always_comb begin
    half_v    = lane[1] ? word[31:16] : word[15:0];
    lane_byte = word[{lane, 3'b000} +: 8];
    rd        = word;
    case (op)
      DM_H:    rd = {{16{half_v[15]}}, half_v};
      DM_HU:   rd = {16'h0000, half_v};
      DM_B:    rd = {{24{lane_byte[7]}}, lane_byte};
      DM_BU:   rd = {24'h000000, lane_byte};
      default: rd = word;
    endcase
  end

endmodule

// File: rtl/data_mem.sv
// Data memory stage: word-organised array with byte/half/word stores on the
// clock edge and combinational, extended loads.
module data_mem
  import dm_pkg::*;
#(
  parameter int WORDS = 1024,
  parameter int AW    = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wd,
  input  logic        MemWrite,
  input  logic [2:0]  MemOp,
  output logic [31:0] rd,
  output logic        addr_err,
  output logic        align_err
);

  logic [31:0]   mem [WORDS];
  logic [AW-1:0] idx;
  logic [31:0]   word;
  logic [31:0]   ext_rd;
  logic [31:0]   wdata;
  dm_be_t        be;
  logic          store_en;

  assign idx  = addr[AW+1:2];
  assign word = mem[idx];

  // Anything above the array, or an undefined opcode, is an address error.
  assign addr_err = (|addr[31:AW+2]) || (MemOp > DM_BU);

  always_comb begin
    align_err = 1'b0;
    case (MemOp)
      DM_W:        align_err = (addr[1:0] != 2'b00);
      DM_H, DM_HU: align_err = addr[0];
      default:     align_err = 1'b0;
    endcase
  end

  // Store data is replicated across lanes so the enables alone pick the target.
  always_comb begin
    be    = '0;
    wdata = wd;
    case (MemOp)
      DM_W: be = 4'b1111;
      DM_H, DM_HU: begin
        be    = addr[1] ? 4'b1100 : 4'b0011;
        wdata = {2{wd[15:0]}};
      end
      DM_B, DM_BU: begin
        be    = 4'b0001 << addr[1:0];
        wdata = {4{wd[7:0]}};
      end
      default: be = '0;
    endcase
  end

  assign store_en = MemWrite && !addr_err && !align_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < WORDS; i++) mem[i] <= '0;
    end else if (store_en) begin
      for (int l = 0; l < 4; l++)
        if (be[l]) mem[idx][8*l +: 8] <= wdata[8*l +: 8];
    end
  end

  dm_ext u_ext (
    .word (word),
    .lane (addr[1:0]),
    .op   (MemOp),
    .rd   (ext_rd)
  );

  assign rd = (addr_err || align_err) ? 32'h0 : ext_rd;

endmodule

// File: tb/tb_data_mem.sv
// Bench for data_mem: directed scenarios plus randomized accesses checked
// against a byte-addressed reference memory.
module tb_data_mem;

  localparam int BYTES = 4096;

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] wd;
  logic        MemWrite;
  logic [2:0]  MemOp;
  logic [31:0] rd;
  logic        addr_err;
  logic        align_err;

  int checks   = 0;
  int failures = 0;

  logic [7:0] ref_mem [BYTES];

  data_mem #(.WORDS(1024), .AW(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .addr      (addr),
    .wd        (wd),
    .MemWrite  (MemWrite),
    .MemOp     (MemOp),
    .rd        (rd),
    .addr_err  (addr_err),
    .align_err (align_err)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // reference model
  function automatic logic ref_addr_err(input logic [31:0] a, input logic [2:0] op);
    return (a >= BYTES) || (op > 3'd4);
  endfunction

  function automatic logic ref_align_err(input logic [31:0] a, input logic [2:0] op);
    if (op == 3'd0) return (a % 4) != 0;
    if (op == 3'd1 || op == 3'd2) return (a % 2) != 0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a, input logic [2:0] op);
    int b;
    logic [15:0] h;
    if (ref_addr_err(a, op) || ref_align_err(a, op)) return 32'h0;
    b = int'(a);
    h = {ref_mem[b+1], ref_mem[b]};
    case (op)
      3'd0:    return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
      3'd1:    return {{16{h[15]}}, h};
      3'd2:    return {16'h0, h};
      3'd3:    return {{24{ref_mem[b][7]}}, ref_mem[b]};
      default: return {24'h0, ref_mem[b]};
    endcase
  endfunction

  function automatic int ref_size(input logic [2:0] op);
    if (op == 3'd0) return 4;
    if (op == 3'd1 || op == 3'd2) return 2;
    return 1;
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] op);
    if (ref_addr_err(a, op) || ref_align_err(a, op)) return;
    for (int k = 0; k < ref_size(op); k++) ref_mem[int'(a) + k] = d[8*k +: 8];
  endtask

  task automatic ref_clear();
    for (int i = 0; i < BYTES; i++) ref_mem[i] = 8'h00;
  endtask

  // driver tasks
  task automatic check_outputs(input string tag);
    check_eq({tag, "_rd"}, rd, ref_rd(addr, MemOp));
    check_eq({tag, "_addr_err"}, {31'h0, addr_err}, {31'h0, ref_addr_err(addr, MemOp)});
    check_eq({tag, "_align_err"}, {31'h0, align_err}, {31'h0, ref_align_err(addr, MemOp)});
  endtask

  // One access: outputs checked before the edge (old data) and after it.
  task automatic do_op(input logic [31:0] a, input logic [31:0] d, input logic we,
                       input logic [2:0] op, input string tag);
    @(negedge clk);
    addr = a; wd = d; MemWrite = we; MemOp = op;
    #1;
    check_outputs({tag, "_pre"});
    @(posedge clk);
    if (we) ref_store(a, d, op);
    #1;
    check_outputs({tag, "_post"});
  endtask

  task automatic load_const(input logic [31:0] a, input logic [2:0] op,
                            input logic [31:0] exp, input string tag);
    @(negedge clk);
    addr = a; wd = 32'h0; MemWrite = 1'b0; MemOp = op;
    #1;
    check_eq(tag, rd, exp);
  endtask

  initial begin
    logic [31:0] ra;
    logic [2:0]  rop;
    int          sel;

    reset = 1'b1; addr = 32'h0000_1000; wd = 32'h0; MemWrite = 1'b0; MemOp = 3'd0;
    ref_clear();
    #3;
    check_eq("reset_flag_addr_err", {31'h0, addr_err}, 32'h1);
    check_eq("reset_rd", rd, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    load_const(32'h0, 3'd0, 32'h0, "reset_load_w0");
    do_op(32'h10, 32'h1234_5678, 1'b1, 3'd0, "st_w_10");
    load_const(32'h10, 3'd0, 32'h1234_5678, "ld_w_10");

    do_op(32'h21, 32'h0000_00AB, 1'b1, 3'd3, "st_b_21");
    do_op(32'h23, 32'h0000_00CD, 1'b1, 3'd3, "st_b_23");
    load_const(32'h20, 3'd0, 32'hCD00_AB00, "ld_w_20");
    load_const(32'h21, 3'd3, 32'hFFFF_FFAB, "ld_b_21");
    load_const(32'h21, 3'd4, 32'h0000_00AB, "ld_bu_21");
    load_const(32'h22, 3'd2, 32'h0000_CD00, "ld_hu_22");

    do_op(32'h32, 32'h0000_8001, 1'b1, 3'd1, "st_h_32");
    load_const(32'h32, 3'd1, 32'hFFFF_8001, "ld_h_32");
    load_const(32'h30, 3'd2, 32'h0000_0000, "ld_hu_30");

    do_op(32'h40, 32'h0102_0304, 1'b1, 3'd0, "st_w_40");
    do_op(32'h41, 32'hDEAD_BEEF, 1'b1, 3'd0, "st_w_41_misaligned");
    check_eq("align_err_w_41", {31'h0, align_err}, 32'h1);
    load_const(32'h40, 3'd0, 32'h0102_0304, "ld_w_40_unchanged");
    do_op(32'h43, 32'h0, 1'b0, 3'd1, "ld_h_43");
    check_eq("ld_h_43_rd_zero", rd, 32'h0);

    do_op(32'h0000_1000, 32'hA5A5_A5A5, 1'b1, 3'd0, "st_w_1000");
    check_eq("addr_err_1000", {31'h0, addr_err}, 32'h1);
    load_const(32'h0, 3'd0, 32'h0, "ld_w_0_after_oob");
    do_op(32'h0000_0FFC, 32'h5A5A_0FFC, 1'b1, 3'd0, "st_w_ffc");
    load_const(32'h0FFC, 3'd0, 32'h5A5A_0FFC, "ld_w_ffc");
    load_const(32'h0FFF, 3'd4, 32'h0000_005A, "ld_bu_fff_top");
    do_op(32'h0FFF, 32'h0000_0077, 1'b1, 3'd3, "st_b_fff_top");

    for (int i = 0; i < 250; i++) begin
      sel = $urandom_range(0, 9);
      if (sel < 6)       ra = 32'($urandom_range(0, 127));
      else if (sel < 8)  ra = 32'(BYTES - 64 + $urandom_range(0, 63));
      else if (sel == 8) ra = 32'(BYTES + $urandom_range(0, 63));
      else               ra = $urandom;
      rop = ($urandom_range(0, 5) == 5) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      do_op(ra, $urandom, 1'($urandom_range(0, 1)), rop, "rand");
    end

    do_op(32'h50, 32'hFFFF_FFFF, 1'b1, 3'd0, "st_w_50");
    #1 reset = 1'b1;
    #1 reset = 1'b0;
    ref_clear();
    addr = 32'h50; MemWrite = 1'b0; MemOp = 3'd0;
    #1;
    check_eq("async_reset_ld_w_50", rd, 32'h0);

    @(negedge clk);
    reset = 1'b1;
    addr = 32'h60; wd = 32'hCAFE_F00D; MemWrite = 1'b1; MemOp = 3'd0;
    @(posedge clk);
    #1;
    check_eq("reset_held_rd", rd, 32'h0);
    @(negedge clk);
    reset = 1'b0; MemWrite = 1'b0;
    load_const(32'h60, 3'd0, 32'h0, "store_during_reset_lost");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
